// File: rtl/fifo_rr_arbiter.sv
// Round-robin arbiter that lets NUM_REQ requesters share one sync_fifo write port.
// A winner owns the port for up to MAX_BURST beats, or until it drops valid.
module fifo_rr_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 4
) (
  input  logic                                    clk,
  input  logic                                    rst_n,
  input  logic [NUM_REQ-1:0]                      req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]           req_data,
  output logic [NUM_REQ-1:0]                      req_ready,
  input  logic                                    fifo_full,
  output logic                                    fifo_wr_en,
  output logic [$clog2(NUM_REQ)+DATA_WIDTH-1:0]   fifo_din,
  output logic [NUM_REQ-1:0]                      grant,
  output logic                                    busy
);

  localparam int ID_WIDTH   = $clog2(NUM_REQ);
  localparam int BCNT_WIDTH = $clog2(MAX_BURST + 1);

  localparam logic [ID_WIDTH-1:0]   LAST_ID_INIT = ID_WIDTH'(NUM_REQ - 1);
  localparam logic [BCNT_WIDTH-1:0] FINAL_BEAT   = BCNT_WIDTH'(MAX_BURST - 1);

  typedef enum logic {
    IDLE = 1'b0,
    OWN  = 1'b1
  } state_t;

  state_t                    state;
  logic [ID_WIDTH-1:0]       gid;
  logic [ID_WIDTH-1:0]       last_id;
  logic [ID_WIDTH-1:0]       win_id;
  logic [BCNT_WIDTH-1:0]     bcnt;
  logic [NUM_REQ-1:0]        grant_q;
  logic                      owner_valid;
  logic [DATA_WIDTH-1:0]     owner_data;
  logic                      xfer;
  logic                      last_beat;
  logic                      release_own;

  // Search starts just after the previous owner, so it becomes lowest priority.
  function automatic logic [ID_WIDTH-1:0] rr_pick(
    input logic [NUM_REQ-1:0]  valid,
    input logic [ID_WIDTH-1:0] last
  );
    logic [ID_WIDTH-1:0] pick;
    logic [ID_WIDTH-1:0] cand;
    logic                found;
    pick  = '0;
    found = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = ID_WIDTH'((int'(last) + k) % NUM_REQ);
      if (!found && valid[cand]) begin
        pick  = cand;
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  function automatic logic [NUM_REQ-1:0] to_onehot(input logic [ID_WIDTH-1:0] id);
    logic [NUM_REQ-1:0] vec;
    vec     = '0;
    vec[id] = 1'b1;
    return vec;
  endfunction

  always_comb begin
    win_id      = rr_pick(req_valid, last_id);
    owner_valid = req_valid[gid];
    owner_data  = req_data[gid*DATA_WIDTH +: DATA_WIDTH];
    xfer        = (state == OWN) && owner_valid && !fifo_full;
    last_beat   = xfer && (bcnt == FINAL_BEAT);
    release_own = (state == OWN) && (!owner_valid || last_beat);
  end

  // Write-port side is combinational off the registered owner.
  always_comb begin
    req_ready  = ((state == OWN) && !fifo_full) ? grant_q : '0;
    fifo_wr_en = xfer;
    fifo_din   = xfer ? {gid, owner_data} : '0;
    grant      = grant_q;
    busy       = (state == OWN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      grant_q <= '0;
      gid     <= '0;
      bcnt    <= '0;
      last_id <= LAST_ID_INIT;
    end else begin
      case (state)
        IDLE: begin
          if (|req_valid) begin
            state   <= OWN;
            gid     <= win_id;
            grant_q <= to_onehot(win_id);
            bcnt    <= '0;
          end
        end
        OWN: begin
          if (xfer) begin
            bcnt <= bcnt + BCNT_WIDTH'(1);
          end
          if (release_own) begin
            state   <= IDLE;
            grant_q <= '0;
            last_id <= gid;
          end
        end
        default: begin
          state   <= IDLE;
          grant_q <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_rr_arbiter.sv
// Scoreboard bench for fifo_rr_arbiter: directed scenarios followed by random traffic,
// checked against a cycle-level behavioural model of the arbitration rules.
module tb_fifo_rr_arbiter;

  localparam int N   = 4;
  localparam int DW  = 8;
  localparam int MB  = 4;
  localparam int IDW = 2;

  logic              clk       = 1'b0;
  logic              rst_n     = 1'b0;
  logic [N-1:0]      req_valid = '0;
  logic [N*DW-1:0]   req_data  = '0;
  logic              fifo_full = 1'b0;
  logic [N-1:0]      req_ready;
  logic [N-1:0]      grant;
  logic              fifo_wr_en;
  logic              busy;
  logic [IDW+DW-1:0] fifo_din;

  fifo_rr_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .MAX_BURST(MB)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .fifo_full  (fifo_full),
    .fifo_wr_en (fifo_wr_en),
    .fifo_din   (fifo_din),
    .grant      (grant),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: owner index, beats written, previous owner.
  bit m_own;
  int m_g;
  int m_bcnt;
  int m_last;

  logic [N-1:0]      e_grant = '0;
  logic [N-1:0]      e_ready = '0;
  logic              e_wr    = 1'b0;
  logic              e_busy  = 1'b0;
  logic [IDW+DW-1:0] exp_q[$];

  int           wr_cnt  = 0;
  int           gnt_cyc = 0;
  int           seen_q[$];
  logic [N-1:0] prev_grant = '0;
  logic [N*DW-1:0] data_fix = 32'h13121110;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int id_of(input logic [N-1:0] g);
    int id;
    id = -1;
    for (int i = 0; i < N; i++) if (g[i]) id = i;
    return id;
  endfunction

  task automatic m_reset();
    m_own  = 1'b0;
    m_g    = 0;
    m_bcnt = 0;
    m_last = N - 1;
  endtask

  task automatic m_step();
    bit found;
    bit moved;
    if (!m_own) begin
      if (req_valid != '0) begin
        found = 1'b0;
        for (int k = 1; k <= N; k++) begin
          if (!found && req_valid[(m_last + k) % N]) begin
            m_g   = (m_last + k) % N;
            found = 1'b1;
          end
        end
        m_own  = 1'b1;
        m_bcnt = 0;
      end
    end else begin
      moved = req_valid[m_g] && !fifo_full;
      if (moved) m_bcnt++;
      if (!req_valid[m_g] || m_bcnt == MB) begin
        m_own  = 1'b0;
        m_last = m_g;
      end
    end
  endtask

  task automatic m_eval();
    logic [IDW-1:0] gid;
    e_grant = '0;
    if (m_own) e_grant[m_g] = 1'b1;
    e_busy  = m_own;
    e_wr    = m_own && req_valid[m_g] && !fifo_full;
    e_ready = (m_own && !fifo_full) ? e_grant : '0;
    if (e_wr) begin
      gid = m_g[IDW-1:0];
      exp_q.push_back({gid, req_data[m_g*DW +: DW]});
    end
  endtask

  task automatic drive(input logic [N-1:0] v, input logic f, input logic [N*DW-1:0] d);
    req_valid = v;
    fifo_full = f;
    req_data  = d;
    m_eval();
  endtask

  task automatic tick(input logic [N-1:0] v, input logic f, input logic [N*DW-1:0] d);
    @(posedge clk);
    if (rst_n) m_step();
    #1;
    drive(v, f, d);
  endtask

  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_counts();
    wr_cnt  = 0;
    gnt_cyc = 0;
    seen_q.delete();
  endtask

  always @(negedge clk) begin
    logic [IDW+DW-1:0] exp_din;
    check("grant", grant, e_grant);
    check("req_ready", req_ready, e_ready);
    check("busy", busy, e_busy);
    check("fifo_wr_en", fifo_wr_en, e_wr);
    check("wr_while_full", fifo_wr_en && fifo_full, 0);
    check("grant_onehot0", $onehot0(grant), 1);
    if (fifo_wr_en === 1'b1) begin
      wr_cnt++;
      check("din_id_vs_grant", fifo_din[IDW+DW-1:DW], id_of(grant));
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_beat: got %0h expected no write at %0t", fifo_din, $time);
      end else begin
        exp_din = exp_q.pop_front();
        check("fifo_din", fifo_din, exp_din);
      end
    end else begin
      check("din_idle_zero", fifo_din, 0);
    end
    if (grant != '0) gnt_cyc++;
    if (grant != '0 && prev_grant == '0) seen_q.push_back(id_of(grant));
    prev_grant = grant;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    int exp_order[5];
    m_reset();
    repeat (3) @(posedge clk);
    #1;
    drive('1, 1'b0, data_fix);
    #1;
    check("rst_grant", grant, 0);
    check("rst_busy", busy, 0);
    check("rst_ready", req_ready, 0);
    check("rst_wr_en", fifo_wr_en, 0);
    check("rst_din", fifo_din, 0);

    // All four requesting: 0,1,2,3,0 with four beats each.
    rst_n = 1'b1;
    clear_counts();
    repeat (24) tick('1, 1'b0, data_fix);
    tick('0, 1'b0, data_fix);
    settle();
    exp_order = '{0, 1, 2, 3, 0};
    check("rr_order_count", seen_q.size(), 5);
    for (int k = 0; k < 5 && k < seen_q.size(); k++) check("rr_order", seen_q[k], exp_order[k]);
    check("rr_writes", wr_cnt, 20);

    // Requester 2 alone, drops valid after three beats.
    clear_counts();
    tick(4'b0100, 1'b0, data_fix);
    repeat (3) tick(4'b0100, 1'b0, data_fix);
    tick('0, 1'b0, data_fix);
    tick('0, 1'b0, data_fix);
    settle();
    check("drop_grant_cycles", gnt_cyc, 4);
    check("drop_writes", wr_cnt, 3);

    // Requester 1 stalled by fifo_full in burst cycles 2-4.
    clear_counts();
    tick(4'b0010, 1'b0, data_fix);
    tick(4'b0010, 1'b0, data_fix);
    repeat (3) tick(4'b0010, 1'b1, data_fix);
    repeat (3) tick(4'b0010, 1'b0, data_fix);
    tick('0, 1'b0, data_fix);
    settle();
    check("stall_grant_cycles", gnt_cyc, 7);
    check("stall_writes", wr_cnt, 4);

    // Make 3 the previous owner, then 0 and 3 compete.
    tick(4'b1000, 1'b0, data_fix);
    tick(4'b1000, 1'b0, data_fix);
    tick('0, 1'b0, data_fix);
    tick('0, 1'b0, data_fix);
    settle();
    clear_counts();
    repeat (10) tick(4'b1001, 1'b0, data_fix);
    tick('0, 1'b0, data_fix);
    settle();
    check("wrap_order_count", seen_q.size(), 2);
    if (seen_q.size() >= 2) begin
      check("wrap_first", seen_q[0], 0);
      check("wrap_second", seen_q[1], 3);
    end
    check("wrap_writes", wr_cnt, 8);

    // Reset in the middle of a burst after two beats.
    clear_counts();
    repeat (4) tick('1, 1'b0, data_fix);
    #2;
    rst_n = 1'b0;
    m_reset();
    exp_q.delete();
    m_eval();
    #1;
    check("midrst_wr_en", fifo_wr_en, 0);
    check("midrst_grant", grant, 0);
    check("midrst_busy", busy, 0);
    check("midrst_ready", req_ready, 0);
    check("midrst_din", fifo_din, 0);
    check("midrst_beats_before", wr_cnt, 2);
    @(posedge clk);
    #1;
    check("midrst_hold_busy", busy, 0);
    rst_n = 1'b1;
    clear_counts();
    repeat (4) tick('1, 1'b0, data_fix);
    tick('0, 1'b0, data_fix);
    settle();
    check("postrst_grants", seen_q.size(), 1);
    if (seen_q.size() >= 1) check("postrst_first", seen_q[0], 0);
    check("postrst_writes", wr_cnt, 4);

    // Random traffic.
    for (int c = 0; c < 2000; c++) begin
      logic [N-1:0] v;
      for (int i = 0; i < N; i++) v[i] = ($urandom_range(0, 9) < 8);
      tick(v, ($urandom_range(0, 9) < 3), $urandom);
    end
    repeat (6) tick('0, 1'b0, data_fix);
    settle();
    check("scoreboard_drain", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
